// File: rtl/wishbone_spram_burst.sv
// Wishbone B4 single-port RAM slave with registered-feedback bursts.
//
// Ports:
//   clk_i, rst_i   clock and synchronous active-high reset
//   adr_i          word address; decoded against BASE_ADDRESS above DEPTH_LOG2
//   dat_i / dat_o  write data / read data (dat_o is 0 whenever ack_o is low)
//   we_i, sel_i    write enable, byte-lane enables
//   stb_i, cyc_i   strobe, bus cycle
//   cti_i          cycle type: 000 classic, 010 incrementing, 111 end of burst
//   ack_o, err_o   beat acknowledge, error (unsupported cti or we change mid-burst)
//
// States:
//   S_IDLE  | waiting for a decoded request
//   S_WAIT  | counting wait states; acks the first beat when the count reaches 0
//   S_BURST | acking one beat per strobed cycle from the internal word counter
module wishbone_spram_burst #(
  parameter int                         ADDRESS_WIDTH = 16,
  parameter int                         DATA_WIDTH    = 8,
  parameter int                         DATA_BYTES    = 1,
  parameter logic [ADDRESS_WIDTH-1:0]   BASE_ADDRESS  = 16'h8000,
  parameter int                         DEPTH_LOG2    = 10,
  parameter int                         WAIT_STATES   = 0
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [ADDRESS_WIDTH-1:0] adr_i,
  input  logic [DATA_WIDTH-1:0]    dat_i,
  output logic [DATA_WIDTH-1:0]    dat_o,
  input  logic                     we_i,
  input  logic [DATA_BYTES-1:0]    sel_i,
  input  logic                     stb_i,
  input  logic                     cyc_i,
  input  logic [2:0]               cti_i,
  output logic                     ack_o,
  output logic                     err_o
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST} state_e;

  state_e                  state_q, state_d;
  logic [DEPTH_LOG2-1:0]   idx_q, idx_d;
  logic                    we_q, we_d;
  logic [2:0]              wcnt_q, wcnt_d;
  logic                    err_q, err_d;
  logic                    beat;
  logic                    hit;
  logic                    cti_ok;
  logic                    wr_en;

  logic [DATA_WIDTH-1:0]   mem_q [0:(1<<DEPTH_LOG2)-1];

  assign hit    = cyc_i & stb_i &
                  (adr_i[ADDRESS_WIDTH-1:DEPTH_LOG2] == BASE_ADDRESS[ADDRESS_WIDTH-1:DEPTH_LOG2]);
  assign cti_ok = (cti_i == 3'b000) | (cti_i == 3'b010) | (cti_i == 3'b111);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    we_d    = we_q;
    wcnt_d  = wcnt_q;
    err_d   = 1'b0;
    beat    = 1'b0;
    case (state_q)
      S_IDLE: begin
        // While err_o is showing, the master is still holding the rejected
        // request; ignoring it keeps err_o to a single cycle.
        if (hit && !err_q) begin
          if (cti_ok) begin
            state_d = S_WAIT;
            idx_d   = adr_i[DEPTH_LOG2-1:0];
            we_d    = we_i;
            wcnt_d  = 3'(WAIT_STATES);
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (!cyc_i) begin
          state_d = S_IDLE;
        end else if (wcnt_q != 3'd0) begin
          wcnt_d = wcnt_q - 3'd1;
        end else if (stb_i) begin
          beat = 1'b1;
          if (cti_i == 3'b010) begin
            state_d = S_BURST;
            idx_d   = idx_q + DEPTH_LOG2'(1);
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_BURST: begin
        // Beat addresses come from idx_q only, so the burst wraps inside
        // the RAM even when the master's address leaves the decode window.
        if (!cyc_i) begin
          state_d = S_IDLE;
        end else if (stb_i) begin
          if (we_i != we_q) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            beat = 1'b1;
            if (cti_i == 3'b010) begin
              idx_d = idx_q + DEPTH_LOG2'(1);
            end else begin
              state_d = S_IDLE;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      we_q    <= 1'b0;
      wcnt_q  <= 3'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      we_q    <= we_d;
      wcnt_q  <= wcnt_d;
      err_q   <= err_d;
    end
  end

  // A beat landing on a reset edge is neither acked nor written.
  assign ack_o = beat & ~rst_i;
  assign err_o = err_q;
  assign wr_en = ack_o & we_q;
  assign dat_o = (ack_o && !we_q) ? mem_q[idx_q] : '0;

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int b = 0; b < DATA_BYTES; b++) begin
        if (sel_i[b]) begin
          mem_q[idx_q][8*b +: 8] <= dat_i[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_wishbone_spram_burst.sv
module tb_wishbone_spram_burst;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic [15:0] adr;
  logic [7:0]  dw, dr;
  logic        we, stb, cyc, ack, err;
  logic [0:0]  sel;
  logic [2:0]  cti;

  logic [15:0] b_adr, b_dw, b_dr;
  logic        b_we, b_stb, b_cyc, b_ack, b_err;
  logic [1:0]  b_sel;
  logic [2:0]  b_cti;

  wishbone_spram_burst dut (
    .clk_i(clk), .rst_i(rst), .adr_i(adr), .dat_i(dw), .dat_o(dr), .we_i(we),
    .sel_i(sel), .stb_i(stb), .cyc_i(cyc), .cti_i(cti), .ack_o(ack), .err_o(err)
  );

  wishbone_spram_burst #(
    .DATA_WIDTH(16), .DATA_BYTES(2), .WAIT_STATES(2)
  ) dut_b (
    .clk_i(clk), .rst_i(rst), .adr_i(b_adr), .dat_i(b_dw), .dat_o(b_dr), .we_i(b_we),
    .sel_i(b_sel), .stb_i(b_stb), .cyc_i(b_cyc), .cti_i(b_cti), .ack_o(b_ack), .err_o(b_err)
  );

  int checks = 0;
  int errors = 0;
  int overlap = 0;
  int dat_bad = 0;
  bit mon_en = 1'b0;

  logic [7:0] ref_mem   [1024];
  bit         ref_valid [1024];
  logic [7:0] wbuf   [16];
  logic [7:0] rbuf   [16];
  logic       selbuf [16];

  typedef struct {
    logic [15:0] a;
    logic        w;
    logic [7:0]  d;
    logic [2:0]  ct;
    int          exp_lat;
    bit          exp_err;
    logic [7:0]  exp_rd;
  } vec_t;
  vec_t tbl [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic bus_idle();
    cyc = 0; stb = 0; we = 0; cti = 3'b000; adr = '0; dw = '0; sel = 1'b1;
  endtask

  task automatic ref_write(input logic [15:0] a, input int i, input logic [7:0] d);
    int idx;
    idx = (int'(a[9:0]) + i) % 1024;
    ref_mem[idx]   = d;
    ref_valid[idx] = 1'b1;
  endtask

  // Holds one request until ack/err or 16 cycles; lat = cycles after the request was first driven.
  task automatic single(input logic [15:0] a, input logic w, input logic [7:0] d, input logic [2:0] ct,
                        output int lat, output bit got_err, output logic [7:0] rd);
    lat = -1; got_err = 1'b0; rd = '0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      cyc = 1; stb = 1; adr = a; we = w; dw = d; cti = ct; sel = 1'b1;
      #1;
      if (ack || err) begin
        lat = c; got_err = err; rd = dr;
        break;
      end
    end
    @(negedge clk);
    bus_idle();
    #1;
  endtask

  // Incrementing burst of n beats from wbuf/selbuf; optional random stb stalls after the first beat.
  task automatic burst(input logic [15:0] a, input logic w, input int n, input bit stalls,
                       output int lat, output int gaps, output int bad);
    int beat;
    int c;
    bit s;
    beat = 0; c = 0; lat = -1; gaps = 0; bad = 0;
    while (beat < n && c < 64) begin
      @(negedge clk);
      s = !(stalls && beat > 0 && $urandom_range(3) == 0);
      cyc = 1; stb = s; we = w; adr = a + 16'(beat); dw = wbuf[beat]; sel = selbuf[beat];
      cti = (n == 1) ? 3'b000 : ((beat == n - 1) ? 3'b111 : 3'b010);
      #1;
      if (err) bad++;
      if (!s && ack) bad++;
      if (ack) begin
        if (lat < 0) lat = c;
        if (!w) rbuf[beat] = dr;
        beat++;
      end else if (s && lat >= 0) begin
        gaps++;
      end
      c++;
    end
    @(negedge clk);
    bus_idle();
    #1;
    if (beat < n) lat = -2;
  endtask

  task automatic single_b(input logic [15:0] a, input logic w, input logic [15:0] d, input logic [1:0] s,
                          output int lat, output logic [15:0] rd);
    lat = -1; rd = '0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      b_cyc = 1; b_stb = 1; b_adr = a; b_we = w; b_dw = d; b_sel = s; b_cti = 3'b000;
      #1;
      if (b_ack || b_err) begin
        lat = c; rd = b_dr;
        break;
      end
    end
    @(negedge clk);
    b_cyc = 0; b_stb = 0; b_we = 0; b_adr = '0; b_dw = '0; b_sel = '0;
    #1;
  endtask

  always @(negedge clk) begin
    #2;
    if (mon_en) begin
      if ((ack && err) || (b_ack && b_err)) overlap++;
      if (!ack && dr != 8'h00) dat_bad++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, gaps, bad, idx, acks;
    bit gerr, got;
    logic [7:0] rd;
    logic [15:0] rdb;
    logic [15:0] start;

    for (int i = 0; i < 1024; i++) ref_valid[i] = 1'b0;
    for (int i = 0; i < 16; i++) selbuf[i] = 1'b1;
    rst = 1;
    bus_idle();
    b_cyc = 0; b_stb = 0; b_we = 0; b_adr = '0; b_dw = '0; b_sel = '0; b_cti = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_ack", 32'(ack), 0);
    chk("reset_err", 32'(err), 0);
    rst = 0;
    #1;
    chk("reset_dat", 32'(dr), 0);
    mon_en = 1'b1;

    // Classic accesses, misses and unsupported cycle types.
    tbl[0]  = '{16'h8003, 1'b1, 8'hA5, 3'b000,  1, 1'b0, 8'h00};
    tbl[1]  = '{16'h8003, 1'b0, 8'h00, 3'b000,  1, 1'b0, 8'hA5};
    tbl[2]  = '{16'h8000, 1'b1, 8'h5A, 3'b111,  1, 1'b0, 8'h00};
    tbl[3]  = '{16'h8000, 1'b1, 8'hFF, 3'b001,  1, 1'b1, 8'h00};
    tbl[4]  = '{16'h8000, 1'b0, 8'h00, 3'b000,  1, 1'b0, 8'h5A};
    tbl[5]  = '{16'h7FFF, 1'b0, 8'h00, 3'b000, -1, 1'b0, 8'h00};
    tbl[6]  = '{16'h8400, 1'b1, 8'h66, 3'b000, -1, 1'b0, 8'h00};
    tbl[7]  = '{16'h83FF, 1'b1, 8'h3C, 3'b000,  1, 1'b0, 8'h00};
    tbl[8]  = '{16'h83FF, 1'b0, 8'h00, 3'b111,  1, 1'b0, 8'h3C};
    tbl[9]  = '{16'h8003, 1'b1, 8'h77, 3'b110,  1, 1'b1, 8'h00};
    tbl[10] = '{16'h8003, 1'b0, 8'h00, 3'b000,  1, 1'b0, 8'hA5};
    for (int i = 0; i < 11; i++) begin
      single(tbl[i].a, tbl[i].w, tbl[i].d, tbl[i].ct, lat, gerr, rd);
      chk($sformatf("tbl%0d_lat", i), 32'(lat), 32'(tbl[i].exp_lat));
      chk($sformatf("tbl%0d_err", i), 32'(gerr), 32'(tbl[i].exp_err));
      if (!tbl[i].w) chk($sformatf("tbl%0d_rd", i), 32'(rd), 32'(tbl[i].exp_rd));
      if (tbl[i].exp_err) chk($sformatf("tbl%0d_err_one_cycle", i), 32'(err), 0);
      if (tbl[i].w && !tbl[i].exp_err && tbl[i].exp_lat == 1) ref_write(tbl[i].a, 0, tbl[i].d);
    end

    // 8-beat write then read burst from the base.
    for (int i = 0; i < 8; i++) wbuf[i] = 8'(i * 8'h11);
    burst(16'h8000, 1'b1, 8, 1'b0, lat, gaps, bad);
    chk("b8w_lat", 32'(lat), 1);
    chk("b8w_gaps", 32'(gaps), 0);
    for (int i = 0; i < 8; i++) ref_write(16'h8000, i, wbuf[i]);
    burst(16'h8000, 1'b0, 8, 1'b0, lat, gaps, bad);
    chk("b8r_lat", 32'(lat), 1);
    chk("b8r_gaps", 32'(gaps), 0);
    chk("b8r_bad", 32'(bad), 0);
    for (int i = 0; i < 8; i++) chk($sformatf("b8r_d%0d", i), 32'(rbuf[i]), 32'(i * 8'h11));
    single(16'h8003, 1'b0, 8'h00, 3'b000, lat, gerr, rd);
    chk("b8_idle_after_lat", 32'(lat), 1);
    chk("b8_idle_after_rd", 32'(rd), 32'h33);

    // Counter wraps from the last word to word 0.
    for (int i = 0; i < 4; i++) wbuf[i] = 8'(i + 1);
    burst(16'h83FE, 1'b1, 4, 1'b0, lat, gaps, bad);
    chk("wrap_lat", 32'(lat), 1);
    for (int i = 0; i < 4; i++) ref_write(16'h83FE, i, wbuf[i]);
    single(16'h83FE, 1'b0, 8'h00, 3'b000, lat, gerr, rd); chk("wrap_3fe", 32'(rd), 1);
    single(16'h83FF, 1'b0, 8'h00, 3'b000, lat, gerr, rd); chk("wrap_3ff", 32'(rd), 2);
    single(16'h8000, 1'b0, 8'h00, 3'b000, lat, gerr, rd); chk("wrap_000", 32'(rd), 3);
    single(16'h8001, 1'b0, 8'h00, 3'b000, lat, gerr, rd); chk("wrap_001", 32'(rd), 4);

    // cyc_i dropped mid-burst: next request starts from IDLE with normal latency.
    for (int i = 0; i < 4; i++) wbuf[i] = 8'(8'hC0 + i);
    burst(16'h8100, 1'b1, 4, 1'b0, lat, gaps, bad);
    for (int i = 0; i < 4; i++) ref_write(16'h8100, i, wbuf[i]);
    acks = 0;
    for (int c = 0; c < 16 && acks < 2; c++) begin
      @(negedge clk);
      cyc = 1; stb = 1; we = 1; adr = 16'h8100 + 16'(acks); dw = 8'(8'hD0 + acks); sel = 1'b1; cti = 3'b010;
      #1;
      if (ack) acks++;
    end
    chk("drop_acks", 32'(acks), 2);
    ref_write(16'h8100, 0, 8'hD0);
    ref_write(16'h8100, 1, 8'hD1);
    @(negedge clk);
    cyc = 0; stb = 0;
    #1;
    chk("drop_ack_low", 32'(ack), 0);
    burst(16'h8102, 1'b0, 2, 1'b0, lat, gaps, bad);
    chk("drop_restart_lat", 32'(lat), 1);
    chk("drop_d2", 32'(rbuf[0]), 32'hC2);
    chk("drop_d3", 32'(rbuf[1]), 32'hC3);

    // we_i flips mid-burst: one err cycle instead of ack, write skipped.
    wbuf[0] = 8'hE0; wbuf[1] = 8'hE1;
    burst(16'h8200, 1'b1, 2, 1'b0, lat, gaps, bad);
    ref_write(16'h8200, 0, 8'hE0); ref_write(16'h8200, 1, 8'hE1);
    got = 1'b0;
    for (int c = 0; c < 16 && !got; c++) begin
      @(negedge clk);
      cyc = 1; stb = 1; we = 1; adr = 16'h8200; dw = 8'h99; sel = 1'b1; cti = 3'b010;
      #1;
      got = ack;
    end
    chk("mm_first_ack", 32'(got), 1);
    ref_write(16'h8200, 0, 8'h99);
    @(negedge clk);
    adr = 16'h8201; we = 0; dw = 8'h55;
    #1;
    chk("mm_noack", 32'(ack), 0);
    @(negedge clk);
    #1;
    chk("mm_err", 32'(err), 1);
    chk("mm_err_noack", 32'(ack), 0);
    @(negedge clk);
    bus_idle();
    #1;
    chk("mm_err_one_cycle", 32'(err), 0);
    single(16'h8200, 1'b0, 8'h00, 3'b000, lat, gerr, rd); chk("mm_w0", 32'(rd), 32'h99);
    single(16'h8201, 1'b0, 8'h00, 3'b000, lat, gerr, rd); chk("mm_w1", 32'(rd), 32'hE1);

    // Reset during beat 3 of an 8-beat write burst.
    for (int i = 0; i < 8; i++) wbuf[i] = 8'hAA;
    burst(16'h8040, 1'b1, 8, 1'b0, lat, gaps, bad);
    for (int i = 0; i < 8; i++) ref_write(16'h8040, i, 8'hAA);
    idx = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      cyc = 1; stb = 1; we = 1; adr = 16'h8040 + 16'(idx); dw = 8'(8'h10 + idx); sel = 1'b1; cti = 3'b010;
      if (idx == 2) rst = 1;
      #1;
      if (rst) break;
      if (ack) idx++;
    end
    chk("rst_beats_before", 32'(idx), 2);
    @(negedge clk);
    rst = 0;
    #1;
    chk("rst_ack_low", 32'(ack), 0);
    chk("rst_err_low", 32'(err), 0);
    chk("rst_dat_low", 32'(dr), 0);
    @(negedge clk);
    bus_idle();
    ref_write(16'h8040, 0, 8'h10);
    ref_write(16'h8040, 1, 8'h11);
    burst(16'h8040, 1'b0, 8, 1'b0, lat, gaps, bad);
    for (int i = 0; i < 8; i++)
      chk($sformatf("rst_word%0d", i), 32'(rbuf[i]), 32'((i < 2) ? (8'h10 + i) : 8'hAA));

    // Random bursts with stalls and byte-lane masking against the array model.
    for (int it = 0; it < 30; it++) begin
      int n;
      start = 16'h8000 + 16'($urandom_range(1023));
      n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) begin
        wbuf[i] = 8'($urandom);
        selbuf[i] = ($urandom_range(3) != 0);
      end
      burst(start, 1'b1, n, 1'b1, lat, gaps, bad);
      chk("rnd_w_lat", 32'(lat), 1);
      chk("rnd_w_gaps", 32'(gaps), 0);
      chk("rnd_w_bad", 32'(bad), 0);
      for (int i = 0; i < n; i++) if (selbuf[i]) ref_write(start, i, wbuf[i]);
      for (int i = 0; i < 16; i++) selbuf[i] = 1'b1;
      burst(start, 1'b0, n, 1'b1, lat, gaps, bad);
      chk("rnd_r_lat", 32'(lat), 1);
      chk("rnd_r_gaps", 32'(gaps), 0);
      chk("rnd_r_bad", 32'(bad), 0);
      for (int i = 0; i < n; i++) begin
        idx = (int'(start[9:0]) + i) % 1024;
        if (ref_valid[idx]) chk($sformatf("rnd%0d_d%0d", it, i), 32'(rbuf[i]), 32'(ref_mem[idx]));
      end
    end

    // Wait states and byte lanes on the 16-bit instance.
    single_b(16'h8010, 1'b1, 16'h1234, 2'b11, lat, rdb); chk("b16_w1_lat", 32'(lat), 3);
    single_b(16'h8010, 1'b1, 16'hBEEF, 2'b10, lat, rdb); chk("b16_w2_lat", 32'(lat), 3);
    single_b(16'h8010, 1'b0, 16'h0000, 2'b11, lat, rdb); chk("b16_r1_lat", 32'(lat), 3);
    chk("b16_r1", 32'(rdb), 32'hBE34);
    single_b(16'h8010, 1'b1, 16'hFFFF, 2'b00, lat, rdb); chk("b16_sel0_lat", 32'(lat), 3);
    single_b(16'h8010, 1'b1, 16'h55AA, 2'b01, lat, rdb);
    single_b(16'h8010, 1'b0, 16'h0000, 2'b11, lat, rdb); chk("b16_r2", 32'(rdb), 32'hBEAA);

    chk("ack_err_overlap", 32'(overlap), 0);
    chk("dat_nonzero_without_ack", 32'(dat_bad), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wishbone_spram_burst.md
WISHBONE_SPRAM_BURST -- requirements
Module: wishbone_spram_burst

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 16, meaning Wishbone word-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, meaning data bus width; SHALL equal 8*DATA_BYTES.
REQ-003 SHALL have parameter DATA_BYTES, default 1, meaning number of byte lanes / sel_i width.
REQ-004 SHALL have parameter BASE_ADDRESS, default 16'h8000, meaning decode base, aligned to 2**DEPTH_LOG2.
REQ-005 SHALL have parameter DEPTH_LOG2, default 10, meaning log2 of memory depth in words.
REQ-006 SHALL have parameter WAIT_STATES, default 0 (range 0-7), meaning extra cycles before the first ack of a cycle.
REQ-007 SHALL use a single clock and a synchronous, active-high reset: clk_i input 1 (clock); rst_i input 1 (reset).
REQ-008 SHALL have ports: adr_i in ADDRESS_WIDTH (word address); dat_i in DATA_WIDTH (write data); dat_o out DATA_WIDTH (read data); we_i in 1 (write enable); sel_i in DATA_BYTES (byte-lane enables); stb_i in 1 (strobe); cyc_i in 1 (bus cycle); cti_i in 3 (cycle type); ack_o out 1 (acknowledge); err_o out 1 (error).

Function
REQ-009 SHALL decode hit = cyc_i & stb_i & (adr_i[ADDRESS_WIDTH-1:DEPTH_LOG2] == BASE_ADDRESS[ADDRESS_WIDTH-1:DEPTH_LOG2]); word index = adr_i[DEPTH_LOG2-1:0].
REQ-010 SHALL never assert ack_o or err_o for a non-hit request.
REQ-011 SHALL implement states IDLE, WAIT, BURST; IDLE->WAIT on hit with cti_i in {000,010,111}; WAIT->BURST after WAIT_STATES+1 cycles.
REQ-012 SHALL, in IDLE on hit with cti_i in {001,011,100,101,110}, assert err_o for exactly one cycle on the next cycle, perform no write, and return to IDLE.
REQ-013 SHALL assert ack_o for the first beat exactly WAIT_STATES+1 cycles after the request is sampled in IDLE.
REQ-014 SHALL, on a read beat, present mem[word] on dat_o during the ack_o cycle; dat_o is 0 whenever ack_o is low.
REQ-015 SHALL, on a write beat, update on the ack_o cycle edge only byte lanes n where sel_i[n]=1; sel_i all-zero still acks, memory unchanged.
REQ-016 SHALL latch the start word index and we_i at the first beat; an internal counter supplies subsequent beat addresses.
REQ-017 SHALL, if the acked beat has cti_i=010 and stb_i stays high, ack every following cycle (no extra wait states), counter incrementing by 1 modulo 2**DEPTH_LOG2 (wrap from last word to 0).
REQ-018 SHALL end the cycle and return to IDLE after acking a beat with cti_i=000 or 111.
REQ-019 SHALL, if cyc_i drops at any point, return to IDLE next cycle with ack_o low and no further writes; stb_i low with cyc_i high inserts a stall: no ack, counter held.
REQ-020 SHALL, if we_i differs from the latched value during BURST, assert err_o one cycle instead of ack, skip that write, and return to IDLE.
REQ-021 SHALL never assert ack_o and err_o in the same cycle.

Reset
REQ-022 SHALL, with rst_i high at a clock edge, force state IDLE, ack_o=0, err_o=0, dat_o=0 on the following cycle, including mid-burst.
REQ-023 SHALL suppress any memory write on a cycle where rst_i is high; memory contents are not cleared by reset.

Verification
REQ-024 Classic write 8'hA5 to 16'h8003, cti 000, then classic read -> one-cycle ack 1 cycle after request each, dat_o=8'hA5 on read ack.
REQ-025 Write burst 16'h8000, data 00,11,...,77, cti 010 x7 then 111; then same read burst -> 8 consecutive acks each, read returns 00..77 in order, state IDLE after.
REQ-026 DEPTH_LOG2=10, 4-beat write burst from 16'h83FE data 1,2,3,4 -> words 0x3FE,0x3FF,0x000,0x001 hold 1,2,3,4.
REQ-027 Request to 16'h7FFF held 16 cycles -> ack_o and err_o stay 0; cti_i=001 to 16'h8000 with we=1 -> err_o one cycle, word unchanged.
REQ-028 rst_i high during beat 3 of 8-beat write burst -> ack_o 0 next cycle, beats 3-8 not written, beats 1-2 retained.
REQ-029 WAIT_STATES=2, DATA_BYTES=2, sel_i=2'b10 write 16'hBEEF over 16'h1234 -> ack 3 cycles after request, word reads 16'hBE34.
